// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encoding, FSM states, BTB entry layout.
package bp_pkg;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef enum logic {
        BP_INIT,
        BP_RUN
    } bp_state_t;

    // BTB fields are sized for the widest supported PC; narrower configs zero-fill the top bits.
    localparam int unsigned BP_MAX_W = 32;

    typedef struct packed {
        logic                valid;
        logic [BP_MAX_W-1:0] tag;
        logic [BP_MAX_W-1:0] target;
    } btb_entry_t;

    localparam bp_ctr_t BP_CTR_INIT = WNT;

    // Saturating step of a direction counter towards the resolved outcome.
    function automatic bp_ctr_t bp_ctr_step(input bp_ctr_t ctr, input logic taken);
        bp_ctr_t nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module bp_ras
    import bp_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push_i,
    input  logic [PC_W-1:0] push_pc_i,
    input  logic            pop_i,
    output logic            empty_o,
    output logic [PC_W-1:0] top_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q;    // next free slot
    logic [CNT_W-1:0] cnt_q;
    logic [PTR_W-1:0] top_idx;
    logic             replace;

    assign top_idx = ptr_q - PTR_W'(1);
    assign empty_o = (cnt_q == '0);
    assign top_o   = mem_q[top_idx];
    // Push and pop together replace the top entry in place.
    assign replace = push_i && pop_i && !empty_o;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (replace) begin
            ptr_q <= ptr_q;
        end else if (push_i) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Stack storage; not reset, emptiness is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[replace ? top_idx : ptr_q] <= push_pc_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Two-level adaptive branch predictor with tagged BTB and post-reset table sweep.
// Define BP_RAS_EN to build the return-address stack.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned GHR_W     = 2,
    parameter int unsigned HASH_MODE = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             pred_valid,
    input  logic [PC_W-1:0]  pred_pc,
    input  logic             pred_is_jump,
    input  logic             pred_is_call,
    input  logic             pred_is_ret,
    output logic [PC_W-1:0]  pred_next_pc,
    output logic             pred_taken,
    output logic [GHR_W-1:0] pred_ghr,
    output logic             init_done,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispredict,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_hit,
    output logic [31:0]      stat_miss
);

    localparam int unsigned ROWS = 2 ** IDX_W;
    localparam int unsigned COLS = 2 ** GHR_W;

    bp_state_t        state_q;
    logic [IDX_W-1:0] idx_q;
    logic             init_done_q;
    logic [GHR_W-1:0] ghr_q;
    logic [31:0]      total_q, hit_q, miss_q;

    bp_ctr_t    bht_q [ROWS][COLS];
    btb_entry_t btb_q [ROWS];

    logic             run;
    logic             upd_en;
    logic [PC_W-1:0]  pc_inc;
    btb_entry_t       btb_rd;
    bp_ctr_t          ctr_rd;
    logic             tag_hit;
    logic             taken_c;
    logic [PC_W-1:0]  next_pc_c;
    logic             ras_hit;
    logic [PC_W-1:0]  ras_top;
    btb_entry_t       upd_entry;

    // Concat mode uses the GHR as a column; gshare folds it into the row and uses column 0.
    function automatic logic [IDX_W-1:0] bht_row(input logic [PC_W-1:0] pc,
                                                 input logic [GHR_W-1:0] g);
        if (HASH_MODE == 1) return pc[IDX_W-1:0] ^ IDX_W'(g);
        return pc[IDX_W-1:0];
    endfunction

    function automatic logic [GHR_W-1:0] bht_col(input logic [GHR_W-1:0] g);
        if (HASH_MODE == 1) return '0;
        return g;
    endfunction

    assign run    = (state_q == BP_RUN);
    assign upd_en = rstn && run && upd_valid;

`ifdef BP_RAS_EN
    logic ras_empty;

    bp_ras #(
        .PC_W  (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (run && pred_valid && pred_is_call),
        .push_pc_i (pc_inc),
        .pop_i     (run && pred_valid && pred_is_ret),
        .empty_o   (ras_empty),
        .top_o     (ras_top)
    );

    assign ras_hit = pred_valid && pred_is_ret && !ras_empty;
`else
    localparam int unsigned ras_depth_unused = RAS_DEPTH;
    logic ras_hints_unused;

    assign ras_hints_unused = pred_is_call ^ pred_is_ret;
    assign ras_hit          = 1'b0;
    assign ras_top          = '0;
`endif

    // Combinational prediction; reads see table contents from before this cycle's writes.
    always_comb begin
        pc_inc    = pred_pc + PC_W'(1);
        btb_rd    = btb_q[pred_pc[IDX_W-1:0]];
        ctr_rd    = bht_q[bht_row(pred_pc, ghr_q)][bht_col(ghr_q)];
        tag_hit   = btb_rd.valid && (btb_rd.tag == BP_MAX_W'(pred_pc[PC_W-1:IDX_W]));
        taken_c   = 1'b0;
        next_pc_c = pc_inc;
        if (run) begin
            if (ras_hit) begin
                taken_c   = 1'b1;
                next_pc_c = ras_top;
            end else if (pred_is_jump && ctr_rd[1] && tag_hit) begin
                taken_c   = 1'b1;
                next_pc_c = btb_rd.target[PC_W-1:0];
            end
        end
    end

    // BTB entry written on a taken resolution.
    always_comb begin
        upd_entry        = '0;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = BP_MAX_W'(upd_pc[PC_W-1:IDX_W]);
        upd_entry.target = BP_MAX_W'(upd_target);
    end

    // Control FSM: init sweep counter, speculative/repaired GHR, statistics.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= BP_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            ghr_q       <= '0;
            total_q     <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
        end else begin
            case (state_q)
                BP_INIT: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == '1) begin
                        state_q     <= BP_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                BP_RUN: begin
                    if (upd_valid) begin
                        total_q <= total_q + 32'd1;
                        if (upd_mispredict) miss_q <= miss_q + 32'd1;
                        else                hit_q  <= hit_q + 32'd1;
                    end
                    // Repair wins over a same-cycle speculative shift.
                    if (upd_valid && upd_mispredict) begin
                        ghr_q <= {upd_ghr[GHR_W-2:0], upd_taken};
                    end else if (pred_valid && pred_is_jump) begin
                        ghr_q <= {ghr_q[GHR_W-2:0], taken_c};
                    end
                end
            endcase
        end
    end

    // Table writes: sweep one row per cycle during init, then train from resolved jumps.
    always_ff @(posedge clk) begin
        if (state_q == BP_INIT) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                bht_q[idx_q][GHR_W'(c)] <= BP_CTR_INIT;
            end
            btb_q[idx_q].valid <= 1'b0;
        end else if (upd_en) begin
            bht_q[bht_row(upd_pc, upd_ghr)][bht_col(upd_ghr)] <=
                bp_ctr_step(bht_q[bht_row(upd_pc, upd_ghr)][bht_col(upd_ghr)], upd_taken);
            if (upd_taken) begin
                btb_q[upd_pc[IDX_W-1:0]] <= upd_entry;
            end
        end
    end

    assign pred_next_pc = next_pc_c;
    assign pred_taken   = taken_c;
    assign pred_ghr     = ghr_q;
    assign init_done    = init_done_q;
    assign stat_total   = total_q;
    assign stat_hit     = hit_q;
    assign stat_miss    = miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default parameters, IDX_W=8, GHR_W=2, concat hash).
module tb_branch_predictor;

    logic        clk;
    logic        rstn;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_is_jump;
    logic        pred_is_call;
    logic        pred_is_ret;
    logic [31:0] pred_next_pc;
    logic        pred_taken;
    logic [1:0]  pred_ghr;
    logic        init_done;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [1:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] stat_total;
    logic [31:0] stat_hit;
    logic [31:0] stat_miss;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;

    branch_predictor dut (
        .clk            (clk),
        .rstn           (rstn),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_is_jump   (pred_is_jump),
        .pred_is_call   (pred_is_call),
        .pred_is_ret    (pred_is_ret),
        .pred_next_pc   (pred_next_pc),
        .pred_taken     (pred_taken),
        .pred_ghr       (pred_ghr),
        .init_done      (init_done),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_ghr        (upd_ghr),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .stat_total     (stat_total),
        .stat_hit       (stat_hit),
        .stat_miss      (stat_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic [1:0] g,
                           input logic t, input logic [31:0] tgt, input logic mp);
        upd_valid      = v;
        upd_pc         = pc;
        upd_ghr        = g;
        upd_taken      = t;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    initial begin
        rstn         = 1'b0;
        pred_valid   = 1'b1;
        pred_pc      = 32'h10;
        pred_is_jump = 1'b1;
        pred_is_call = 1'b0;
        pred_is_ret  = 1'b0;
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);

        // 1. Reset, partial sweep, reset again mid-sweep; sweep must restart at idx 0.
        tick();
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        chk("rst_ghr", {62'd0, pred_ghr}, 64'd0);
        chk("rst_stat_total", {32'd0, stat_total}, 64'd0);
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        #1;
        chk("init_next_pc", {32'd0, pred_next_pc}, 64'h11);
        chk("init_taken", {63'd0, pred_taken}, 64'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        // An update during the sweep must be dropped and the GHR held.
        set_upd(1'b1, 32'h20, 2'b01, 1'b1, 32'h8, 1'b1);
        tick();
        cycles = 1;
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        chk("init_ghr_held", {62'd0, pred_ghr}, 64'd0);
        chk("init_upd_dropped", {32'd0, stat_total}, 64'd0);
        while (!init_done && cycles < 1000) begin
            tick();
            cycles++;
        end
        chk("init_cycles", 64'(cycles), 64'd256);
        pred_valid = 1'b0;

        // 2. Two taken updates at 0x10 -> 0x4; same-cycle query sees the old state.
        set_upd(1'b1, 32'h10, 2'b00, 1'b1, 32'h4, 1'b0);
        #1;
        chk("collide_taken", {63'd0, pred_taken}, 64'd0);
        chk("collide_next_pc", {32'd0, pred_next_pc}, 64'h11);
        tick();
        tick();
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t2_next_pc", {32'd0, pred_next_pc}, 64'h4);
        chk("t2_taken", {63'd0, pred_taken}, 64'd1);
        chk("t2_ghr", {62'd0, pred_ghr}, 64'd0);
        chk("t2_total", {32'd0, stat_total}, 64'd2);
        chk("t2_hit", {32'd0, stat_hit}, 64'd2);

        // 3. Same index, different tag.
        pred_pc = 32'h110;
        #1;
        chk("t3_next_pc", {32'd0, pred_next_pc}, 64'h111);
        chk("t3_taken", {63'd0, pred_taken}, 64'd0);

        // 4. Four not-taken updates from 11: 10, 01, 00, 00.
        pred_pc = 32'h10;
        set_upd(1'b1, 32'h10, 2'b00, 1'b0, 32'h0, 1'b0);
        tick();
        chk("t4_after1_taken", {63'd0, pred_taken}, 64'd1);
        tick();
        chk("t4_after2_taken", {63'd0, pred_taken}, 64'd0);
        tick();
        tick();
        chk("t4_total", {32'd0, stat_total}, 64'd6);
        // From 00 one taken step stays not-taken; a second reaches 10.
        set_upd(1'b1, 32'h10, 2'b00, 1'b1, 32'h4, 1'b0);
        tick();
        chk("t4_sat_low", {63'd0, pred_taken}, 64'd0);
        tick();
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        #1;
        chk("t4_retrain_taken", {63'd0, pred_taken}, 64'd1);
        chk("t4_hit", {32'd0, stat_hit}, 64'd8);

        // 5. Train GHR column 3, set GHR=11 by repair, then repair vs speculative shift.
        set_upd(1'b1, 32'h10, 2'b11, 1'b1, 32'h4, 1'b0);
        tick();
        tick();
        set_upd(1'b1, 32'h50, 2'b01, 1'b1, 32'h9, 1'b1);
        tick();
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        chk("t5_ghr_repair", {62'd0, pred_ghr}, 64'h3);
        chk("t5_miss1", {32'd0, stat_miss}, 64'd1);
        pred_pc    = 32'h10;
        pred_valid = 1'b1;
        #1;
        chk("t5_col3_taken", {63'd0, pred_taken}, 64'd1);
        set_upd(1'b1, 32'h10, 2'b01, 1'b0, 32'h0, 1'b1);
        tick();
        set_upd(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0);
        pred_valid = 1'b0;
        chk("t5_ghr_collide", {62'd0, pred_ghr}, 64'h2);
        chk("t5_miss2", {32'd0, stat_miss}, 64'd2);
        chk("t5_total", {32'd0, stat_total}, 64'd12);
        #1;
        chk("t5_col2_taken", {63'd0, pred_taken}, 64'd0);
        chk("t5_col2_next_pc", {32'd0, pred_next_pc}, 64'h11);
        // Plain speculative shifts: not-taken at 0x77, then taken at 0x10.
        pred_valid = 1'b1;
        pred_pc    = 32'h77;
        tick();
        chk("t5_shift_nt", {62'd0, pred_ghr}, 64'h0);
        pred_pc = 32'h10;
        tick();
        chk("t5_shift_t", {62'd0, pred_ghr}, 64'h1);
        pred_valid = 1'b0;

`ifdef BP_RAS_EN
        // 6. Call/return pairing and overflow of a depth-4 stack.
        pred_valid   = 1'b1;
        pred_is_call = 1'b1;
        pred_pc      = 32'h20;
        tick();
        pred_is_call = 1'b0;
        pred_is_ret  = 1'b1;
        pred_pc      = 32'h30;
        #1;
        chk("t6_ret_next_pc", {32'd0, pred_next_pc}, 64'h21);
        chk("t6_ret_taken", {63'd0, pred_taken}, 64'd1);
        tick();
        pred_is_ret  = 1'b0;
        pred_is_call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pred_pc = 32'h40 + 32'(i);
            tick();
        end
        pred_is_call = 1'b0;
        pred_is_ret  = 1'b1;
        pred_pc      = 32'h60;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_ret_stack", {32'd0, pred_next_pc}, 64'(32'h45 - 32'(i)));
            tick();
        end
        #1;
        chk("t6_ret_empty_pc", {32'd0, pred_next_pc}, 64'h61);
        chk("t6_ret_empty_taken", {63'd0, pred_taken}, 64'd0);
        pred_is_ret = 1'b0;
        pred_valid  = 1'b0;
`else
        // 6. Without the stack a return is predicted by BHT/BTB only.
        pred_valid  = 1'b1;
        pred_is_ret = 1'b1;
        pred_pc     = 32'h30;
        #1;
        chk("t6_noras_next_pc", {32'd0, pred_next_pc}, 64'h31);
        chk("t6_noras_taken", {63'd0, pred_taken}, 64'd0);
        pred_is_ret = 1'b0;
        pred_valid  = 1'b0;
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
